// File: rtl/gon_collector.sv
// gon_collector: global output network that returns PE results to the GLB.
// One PE per cycle is chosen by matching (tag_Y, tag_X) against scan-loaded
// row/PE IDs. Its word is queued in a 2-entry FIFO facing the GLB.
module gon_collector #(
    parameter int DATA_BITS   = 32,
    parameter int XID_BITS    = 4,
    parameter int YID_BITS    = 4,
    parameter int NUMS_PE_ROW = 6,
    parameter int NUMS_PE_COL = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [XID_BITS-1:0]                        tag_X,
    input  logic [YID_BITS-1:0]                        tag_Y,
    input  logic                                       set_XID,
    input  logic [XID_BITS-1:0]                        XID_scan_in,
    input  logic                                       set_YID,
    input  logic [YID_BITS-1:0]                        YID_scan_in,
    input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           PE_valid,
    output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0]           PE_ready,
    input  logic [NUMS_PE_ROW*NUMS_PE_COL*DATA_BITS-1:0] PE_data,
    output logic                                       GON_valid,
    input  logic                                       GON_ready,
    output logic [DATA_BITS-1:0]                       GON_data,
    output logic                                       GON_collision
);

    localparam int N = NUMS_PE_ROW * NUMS_PE_COL;

    logic [YID_BITS-1:0]  yid_q [NUMS_PE_ROW];
    logic [XID_BITS-1:0]  xid_q [N];
    logic [DATA_BITS-1:0] fifoMem_q [2];
    logic                 head_q;
    logic [1:0]           count_q;
    logic [1:0]           count_d;
    logic                 collision_q;

    logic [N-1:0]         selOneHot;
    logic [DATA_BITS-1:0] selData;
    logic                 candAny;
    logic                 candMulti;
    logic                 space;
    logic                 push;
    logic                 pop;
    logic                 tailIdx;

    // Row ID scan chain; all-ones marks a row as disabled until configured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NUMS_PE_ROW; r++) yid_q[r] <= '1;
        end else if (set_YID) begin
            yid_q[0] <= YID_scan_in;
            for (int r = 1; r < NUMS_PE_ROW; r++) yid_q[r] <= yid_q[r-1];
        end
    end

    // Per-PE X ID scan chain, same disabled encoding as the row chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) xid_q[k] <= '1;
        end else if (set_XID) begin
            xid_q[0] <= XID_scan_in;
            for (int k = 1; k < N; k++) xid_q[k] <= xid_q[k-1];
        end
    end

    // Match tags, pick the lowest-index valid candidate and flag multiple candidates.
    always_comb begin
        selOneHot = '0;
        selData   = '0;
        candAny   = 1'b0;
        candMulti = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (PE_valid[k] &&
                (yid_q[k / NUMS_PE_COL] == tag_Y) && (yid_q[k / NUMS_PE_COL] != '1) &&
                (xid_q[k] == tag_X) && (xid_q[k] != '1)) begin
                if (candAny) begin
                    candMulti = 1'b1;
                end else begin
                    selOneHot[k] = 1'b1;
                    selData      = PE_data[k*DATA_BITS +: DATA_BITS];
                end
                candAny = 1'b1;
            end
        end
    end

    // Handshake decode; scanning blocks accepts so a word never lands under changing IDs.
    always_comb begin
        space     = (count_q < 2'd2) && !set_XID && !set_YID;
        PE_ready  = space ? selOneHot : '0;
        push      = space && candAny;
        pop       = (count_q != 2'd0) && GON_ready;
        tailIdx   = head_q ^ count_q[0];
        count_d   = count_q;
        if (push && !pop)      count_d = count_q + 2'd1;
        else if (!push && pop) count_d = count_q - 2'd1;
    end

    // Two-entry circular FIFO; simultaneous push/pop at count 1 writes behind the head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifoMem_q[0] <= '0;
            fifoMem_q[1] <= '0;
            head_q       <= 1'b0;
            count_q      <= 2'd0;
        end else begin
            if (push) fifoMem_q[tailIdx] <= selData;
            if (pop)  head_q <= ~head_q;
            count_q <= count_d;
        end
    end

    // Sticky collision flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           collision_q <= 1'b0;
        else if (candMulti) collision_q <= 1'b1;
    end

    assign GON_valid     = (count_q != 2'd0);
    assign GON_data      = fifoMem_q[head_q];
    assign GON_collision = collision_q;

endmodule

// File: doc/gon_collector.md
# gon_collector

Global output network (GON) for the PE array: the return path that moves results from the PEs back to the GLB. Each cycle it selects one producing PE by matching the controller's (tag_Y, tag_X) against per-PE scan-configured IDs. It accepts that PE's word through a valid/ready handshake and queues it in a 2-entry output FIFO that drives the GLB-side handshake. It sits between the PE array outputs and the GLB write port, mirroring the GIN multicast input network.

## Interface
- `DATA_BITS`, default 32: result word width (design-wide define).
- `XID_BITS`, default 4: X ID/tag width.
- `YID_BITS`, default 4: Y ID/tag width.
- `NUMS_PE_ROW`, default 6: PE rows.
- `NUMS_PE_COL`, default 8: PE columns. N = ROW*COL; PE index k = row*COL + col.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted when 0).
- `tag_X` in XID_BITS: target X tag from controller.
- `tag_Y` in YID_BITS: target Y tag from controller.
- `set_XID` in 1: shift the X ID chain one position.
- `XID_scan_in` in XID_BITS: X ID chain input.
- `set_YID` in 1: shift the Y ID chain one position.
- `YID_scan_in` in YID_BITS: Y ID chain input.
- `PE_valid` in N: per-PE result valid.
- `PE_ready` out N: per-PE accept.
- `PE_data` in N*DATA_BITS: per-PE result; PE k occupies bits [DATA_BITS*(k+1)-1 : DATA_BITS*k].
- `GON_valid` out 1: output word available to GLB.
- `GON_ready` in 1: GLB accepts word.
- `GON_data` out DATA_BITS: FIFO head word.
- `GON_collision` out 1: sticky flag, more than one matching PE was valid in the same cycle.

## Operation
- **ID registers.** YID[r] holds one entry per row; XID[k] holds one entry per PE. Both reset to all-ones, which is reserved as "disabled" and never matches.
- **Y chain shift.** On a clock edge with set_YID=1: YID[0] <= YID_scan_in, and YID[r] <= YID[r-1] for r = 1..ROW-1.
- **X chain shift.** On a clock edge with set_XID=1: XID[0] <= XID_scan_in, and XID[k] <= XID[k-1]. After N shifts, the first value shifted in resides in XID[N-1].
- **Hit.** hit[k] = (YID[k/COL] == tag_Y) && (XID[k] == tag_X) && neither ID is all-ones.
- **Candidate and selection.** cand[k] = hit[k] && PE_valid[k]. sel = lowest k with cand[k] set.
- **Space.** space = (count < 2) && !set_XID && !set_YID.
- **Ready.** PE_ready[k] = (k == sel) && space. At most one bit is high. PE_ready is combinational from the tags, IDs, PE_valid and the FIFO count.
- **Push.** A push occurs when any PE_ready[k] && PE_valid[k]. It writes PE_data slice k into the FIFO.
- **FIFO.** 2 entries, count in 0..2. GON_valid = (count != 0). GON_data = head entry.
- **Pop.** A pop occurs when GON_valid && GON_ready.
- **Count update.**
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop together (only possible at count 1): count stays 1, head advances, order preserved.
  - At count 2 no push occurs; a pop drops count to 1.
- **Collision.** If two or more cand bits are set in a cycle, GON_collision is set at the next edge and holds until reset. The lowest-index PE is still serviced.
- **No match.** With no hit, all PE_ready stay 0 and the FIFO is unaffected.
- **Config during data.** When set_XID or set_YID is high, no push occurs; pops continue. New IDs take effect in the cycle after the shift edge.
- **Reset.** Asserting rst at any time immediately clears the FIFO (count=0) and GON_collision, and sets all IDs to all-ones. Words in flight are discarded.

## Timing
- **Reset values.** GON_valid=0, GON_data=0, GON_collision=0, PE_ready=all 0 (IDs are disabled).
- **Latency.** A word accepted at edge t appears on GON_data with GON_valid=1 in cycle t+1. Latency is 1 cycle.
- **Throughput.** 1 word/cycle while GON_ready stays high: steady state count=1 with push and pop on every edge.
- **Backpressure.** With GON_ready low, two words are absorbed, then PE_ready drops to 0.
- **Handshake rules.** GON_valid/GON_data remain stable until popped. PEs must hold PE_valid/PE_data until their ready bit is seen.
- **Tag changes.** tag_X/tag_Y may change every cycle; selection uses the current-cycle values.

## Test plan
- **Scan and single transfer.** Shift YID 0..5 and XID = k%8 (N shifts). Set tag_Y=YID[2], tag_X=XID[19] → PE 19 (row 2, col 3) receives PE_ready. Drive PE_data 0xDEADBEEF → GON_valid rises one cycle later with GON_data=0xDEADBEEF.
- **Streaming.** GON_ready=1, selected PE streams 0x1..0x10 → 16 words out, in order, 1/cycle, at 1-cycle latency.
- **Backpressure.** GON_ready=0 with PE streaming 0xA,0xB,0xC → 0xA and 0xB accepted, PE_ready low for 0xC. Raise GON_ready → outputs 0xA, 0xB, 0xC with no loss or duplication.
- **Collision.** Give PEs 5 and 12 the same (Y,X) IDs and assert valid on both → PE 5 is serviced first, GON_collision=1 from the next cycle and stays high after PE 12 is serviced.
- **Disabled/no-match and config gating.**
  - Right after reset, any tags with all PE_valid=1 → PE_ready=0 and GON_valid=0.
  - set_XID held high mid-stream → no pushes; queued words still drain.
- **Async reset mid-operation.** FIFO holding 2 words, drive rst=0 between edges → GON_valid drops immediately. After release, GON_valid=0, all IDs are disabled and GON_collision=0.
